dcache_tile_port: RTL and testbench



---
 rtl/cherry_dcache_pkg.sv | 30 +++
 rtl/dcache_tile_port_if.sv | 55 +++++
 rtl/dcache_tile_perf_ctr.sv | 30 +++
 rtl/dcache_tile_port.sv | 178 +++++++++++++++++
 tb/tb_dcache_tile_port.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cherry_dcache_pkg.sv
// Shared dcache definitions: default geometry, tile sequencer states and width helpers.
package cherry_dcache_pkg;

    localparam int unsigned DefSz     = 4;
    localparam int unsigned DefLogcnt = 5;
    localparam int unsigned DefBits   = 18;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } tile_state_e;

    // Element address width: 1K elements per bank times the bank count.
    function automatic int unsigned calc_aw(input int unsigned logcnt);
        return 10 + logcnt;
    endfunction

    // Strides are one bit narrower than the address.
    function automatic int unsigned calc_sw(input int unsigned logcnt);
        return calc_aw(logcnt) - 1;
    endfunction

    // One full tile of elements.
    function automatic int unsigned calc_line(input int unsigned sz, input int unsigned bits);
        return bits * sz * sz;
    endfunction

endpackage

// File: rtl/dcache_tile_port_if.sv
// Tile port bundle: command, dcache port and response signals of the tile sequencer.
// slave = the sequencer, master = execute stage plus dcache.
interface dcache_tile_port_if
    import cherry_dcache_pkg::*;
#(
    parameter int unsigned SZ     = DefSz,
    parameter int unsigned LOGCNT = DefLogcnt,
    parameter int unsigned BITS   = DefBits,
    parameter int unsigned TAGW   = 4
);

    localparam int unsigned AW   = calc_aw(LOGCNT);
    localparam int unsigned SW   = calc_sw(LOGCNT);
    localparam int unsigned LINE = calc_line(SZ, BITS);

    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [SW-1:0]   cmd_stride_x;
    logic [SW-1:0]   cmd_stride_y;
    logic [LINE-1:0] cmd_dat;
    logic [TAGW-1:0] cmd_tag;

    logic [AW-1:0]   dc_addr;
    logic [SW-1:0]   dc_stride_x;
    logic [SW-1:0]   dc_stride_y;
    logic [LINE-1:0] dc_dat_w;
    logic            dc_we;
    logic [LINE-1:0] dc_dat_r;
    logic            dc_stall;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [LINE-1:0] rsp_dat;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_is_store;

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_stride_x, cmd_stride_y, cmd_dat, cmd_tag,
        input  dc_dat_r, dc_stall, rsp_ready,
        output cmd_ready,
        output dc_addr, dc_stride_x, dc_stride_y, dc_dat_w, dc_we,
        output rsp_valid, rsp_dat, rsp_tag, rsp_is_store
    );

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_stride_x, cmd_stride_y, cmd_dat, cmd_tag,
        output dc_dat_r, dc_stall, rsp_ready,
        input  cmd_ready,
        input  dc_addr, dc_stride_x, dc_stride_y, dc_dat_w, dc_we,
        input  rsp_valid, rsp_dat, rsp_tag, rsp_is_store
    );

endinterface

// File: rtl/dcache_tile_perf_ctr.sv
// Saturating 32-bit event counter for dcache stall cycles.
module dcache_tile_perf_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q, cnt_d;

    // Count events, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_tile_port.sv
// Tile load/store sequencer on the dcache high-priority tile port.
// Optional feature: define DCACHE_TILE_PERF_EN to add the perf_stall_cnt output.
module dcache_tile_port
    import cherry_dcache_pkg::*;
#(
    parameter int unsigned SZ     = DefSz,
    parameter int unsigned LOGCNT = DefLogcnt,
    parameter int unsigned BITS   = DefBits,
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned TAGW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dcache_tile_port_if.slave bus
`ifdef DCACHE_TILE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned AW   = calc_aw(LOGCNT);
    localparam int unsigned SW   = calc_sw(LOGCNT);
    localparam int unsigned LINE = calc_line(SZ, BITS);
    localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(RD_LAT - 1);

    tile_state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [SW-1:0]   sx_q, sx_d;
    logic [SW-1:0]   sy_q, sy_d;
    logic [LINE-1:0] dat_q, dat_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            dc_we_q, dc_we_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [LINE-1:0] rsp_dat_q, rsp_dat_d;
    logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
    logic            rsp_is_store_q, rsp_is_store_d;

    logic            cmd_take;
    logic            wait_done;

    assign cmd_take  = (state_q == StIdle) && bus.cmd_valid;
    // Last read-latency cycle: the dcache only advances on unstalled cycles.
    assign wait_done = (state_q == StWait) && !bus.dc_stall && (cnt_q == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.cmd_valid) state_d = StIssue;
            StIssue: if (!bus.dc_stall) state_d = StWait;
            StWait:  if (wait_done)     state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values and the decoded cmd_ready.
    always_comb begin
        cnt_d          = cnt_q;
        we_d           = we_q;
        addr_d         = addr_q;
        sx_d           = sx_q;
        sy_d           = sy_q;
        dat_d          = dat_q;
        tag_d          = tag_q;
        dc_we_d        = dc_we_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_dat_d      = rsp_dat_q;
        rsp_tag_d      = rsp_tag_q;
        rsp_is_store_d = rsp_is_store_q;
        bus.cmd_ready  = (state_q == StIdle);

        unique case (state_q)
            StIdle: begin
                if (cmd_take) begin
                    we_d    = bus.cmd_we;
                    addr_d  = bus.cmd_addr;
                    sx_d    = bus.cmd_stride_x;
                    sy_d    = bus.cmd_stride_y;
                    dat_d   = bus.cmd_dat;
                    tag_d   = bus.cmd_tag;
                    dc_we_d = bus.cmd_we;
                end
            end
            StIssue: begin
                if (!bus.dc_stall) begin
                    cnt_d = CntInit;
                end
            end
            StWait: begin
                if (wait_done) begin
                    // Keep dc_we up until now so conflicted banks finish their writes.
                    dc_we_d        = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_dat_d      = we_q ? '0 : bus.dc_dat_r;
                    rsp_tag_d      = tag_q;
                    rsp_is_store_d = we_q;
                end else if (!bus.dc_stall) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            sx_q           <= '0;
            sy_q           <= '0;
            dat_q          <= '0;
            tag_q          <= '0;
            dc_we_q        <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_dat_q      <= '0;
            rsp_tag_q      <= '0;
            rsp_is_store_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            dat_q          <= dat_d;
            tag_q          <= tag_d;
            dc_we_q        <= dc_we_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_dat_q      <= rsp_dat_d;
            rsp_tag_q      <= rsp_tag_d;
            rsp_is_store_q <= rsp_is_store_d;
        end
    end

    assign bus.dc_addr      = addr_q;
    assign bus.dc_stride_x  = sx_q;
    assign bus.dc_stride_y  = sy_q;
    assign bus.dc_dat_w     = dat_q;
    assign bus.dc_we        = dc_we_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_dat      = rsp_dat_q;
    assign bus.rsp_tag      = rsp_tag_q;
    assign bus.rsp_is_store = rsp_is_store_q;

`ifdef DCACHE_TILE_PERF_EN
    logic stall_evt;

    assign stall_evt = bus.dc_stall && ((state_q == StIssue) || (state_q == StWait));

    dcache_tile_perf_ctr u_perf_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_evt),
        .cnt_o (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_dcache_tile_port.sv
// Directed, table-driven bench for dcache_tile_port (SZ=4, LOGCNT=5, BITS=18, RD_LAT=3).
module tb_dcache_tile_port;

    localparam int unsigned AW   = 15;
    localparam int unsigned SW   = 14;
    localparam int unsigned LINE = 288;
    localparam int unsigned TAGW = 4;

    localparam logic [LINE-1:0] JUNK  = {9{32'hFFFF_0000}};
    localparam logic [LINE-1:0] JUNK2 = {9{32'h0F0F_F0F0}};
    localparam logic [LINE-1:0] PAT_A = {9{32'hA5A5_0F0F}};
    localparam logic [LINE-1:0] PAT_B = {9{32'h1357_9BDF}};
    localparam logic [LINE-1:0] PAT_C = {9{32'hDEAD_BEEF}};
    localparam logic [LINE-1:0] PAT_D = {9{32'h0123_4567}};
    localparam logic [LINE-1:0] ST_A  = {144{2'b01}};
    localparam logic [LINE-1:0] ST_B  = {144{2'b10}};

    logic clk;
    logic rst_n;

    dcache_tile_port_if #(.SZ(4), .LOGCNT(5), .BITS(18), .TAGW(TAGW)) bus ();

`ifdef DCACHE_TILE_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    dcache_tile_port #(
        .SZ     (4),
        .LOGCNT (5),
        .BITS   (18),
        .RD_LAT (3),
        .TAGW   (TAGW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef DCACHE_TILE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [SW-1:0]   sx;
        logic [SW-1:0]   sy;
        logic [LINE-1:0] dat;
        logic [TAGW-1:0] tag;
        logic [15:0]     stall_mask; // bit c: dc_stall high in cycle T+c
        logic [LINE-1:0] pat;        // driven on dc_dat_r only in cycle T+sample_cyc
        int              sample_cyc;
        int              rsp_cyc;    // first cycle with rsp_valid
        int              bp;         // cycles of rsp_ready low once rsp_valid is up
        logic            exp_store;
        logic [LINE-1:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [SW-1:0] sx, input logic [SW-1:0] sy,
                                input logic [LINE-1:0] dat, input logic [TAGW-1:0] tag,
                                input logic [15:0] mask, input logic [LINE-1:0] pat,
                                input int sample_cyc, input int rsp_cyc, input int bp,
                                input logic exp_store, input logic [LINE-1:0] exp_dat);
        vec_t v;
        v.we = we; v.addr = addr; v.sx = sx; v.sy = sy; v.dat = dat; v.tag = tag;
        v.stall_mask = mask; v.pat = pat; v.sample_cyc = sample_cyc; v.rsp_cyc = rsp_cyc;
        v.bp = bp; v.exp_store = exp_store; v.exp_dat = exp_dat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LINE-1:0] act,
                       input logic [LINE-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one table command starting in an IDLE cycle and follow it to completion.
    task automatic run_vec(input int i);
        vec_t v;
        bit   done;
        int   k;
        v    = vecs[i];
        done = 1'b0;
        bus.cmd_valid    = 1'b1;
        bus.cmd_we       = v.we;
        bus.cmd_addr     = v.addr;
        bus.cmd_stride_x = v.sx;
        bus.cmd_stride_y = v.sy;
        bus.cmd_dat      = v.dat;
        bus.cmd_tag      = v.tag;
        bus.dc_stall     = 1'b0;
        bus.dc_dat_r     = JUNK;
        bus.rsp_ready    = 1'b0;
        chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
        step();
        // Scramble the command bus to prove the fields were latched.
        bus.cmd_valid    = 1'b0;
        bus.cmd_we       = ~v.we;
        bus.cmd_addr     = ~v.addr;
        bus.cmd_stride_x = ~v.sx;
        bus.cmd_stride_y = ~v.sy;
        bus.cmd_dat      = JUNK2;
        bus.cmd_tag      = ~v.tag;
        for (int c = 1; c <= 40 && !done; c++) begin
            bus.dc_stall = (c < 16) ? v.stall_mask[c] : 1'b0;
            bus.dc_dat_r = (c == v.sample_cyc) ? v.pat : JUNK;
            if (c < v.rsp_cyc) begin
                bus.rsp_ready = 1'b1;
                chk("rsp_valid_early", bus.rsp_valid, 1'b0);
                chk("cmd_ready_busy", bus.cmd_ready, 1'b0);
                chk("dc_we", bus.dc_we, v.we);
                chk("dc_addr", bus.dc_addr, v.addr);
                chk("dc_stride_x", bus.dc_stride_x, v.sx);
                chk("dc_stride_y", bus.dc_stride_y, v.sy);
                chk("dc_dat_w", bus.dc_dat_w, v.dat);
            end else begin
                k = c - v.rsp_cyc;
                bus.rsp_ready = (k >= v.bp);
                chk("rsp_valid", bus.rsp_valid, 1'b1);
                chk("rsp_dat", bus.rsp_dat, v.exp_dat);
                chk("rsp_tag", bus.rsp_tag, v.tag);
                chk("rsp_is_store", bus.rsp_is_store, v.exp_store);
                chk("dc_we_resp", bus.dc_we, 1'b0);
                chk("cmd_ready_resp", bus.cmd_ready, 1'b0);
                if (k >= v.bp) done = 1'b1;
            end
            step();
        end
        chk("rsp_done", done, 1'b1);
        bus.rsp_ready = 1'b0;
        bus.dc_stall  = 1'b0;
        bus.dc_dat_r  = JUNK;
        chk("cmd_ready_after", bus.cmd_ready, 1'b1);
        chk("rsp_valid_after", bus.rsp_valid, 1'b0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_dc_we", bus.dc_we, 1'b0);
        chk("rst_dc_addr", bus.dc_addr, '0);
        chk("rst_dc_stride_x", bus.dc_stride_x, '0);
        chk("rst_dc_dat_w", bus.dc_dat_w, '0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_dat", bus.rsp_dat, '0);
        chk("rst_rsp_tag", bus.rsp_tag, '0);
        chk("rst_rsp_is_store", bus.rsp_is_store, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                 we    addr       sx        sy        dat   tag   mask      pat   smp rsp bp st    exp
        vecs[0] = mk(1'b0, 15'h0040, 14'h0001, 14'h0004, ST_B, 4'h2, 16'h0000, PAT_A, 4, 5, 0, 1'b0, PAT_A);
        vecs[1] = mk(1'b0, 15'h3FF1, 14'h1234, 14'h3ABC, ST_A, 4'h9, 16'h001A, PAT_B, 7, 8, 0, 1'b0, PAT_B);
        vecs[2] = mk(1'b1, 15'h0123, 14'h0002, 14'h0010, ST_A, 4'h5, 16'h0000, PAT_C, 4, 5, 0, 1'b1, '0);
        vecs[3] = mk(1'b0, 15'h7FFF, 14'h3FFF, 14'h0000, ST_B, 4'hF, 16'h0000, PAT_D, 4, 5, 5, 1'b0, PAT_D);
        vecs[4] = mk(1'b1, 15'h5555, 14'h2AAA, 14'h1555, ST_B, 4'hA, 16'h0028, PAT_A, 6, 7, 2, 1'b1, '0);
        vecs[5] = mk(1'b0, 15'h0200, 14'h0001, 14'h0020, ST_A, 4'h7, 16'h0010, PAT_C, 5, 6, 0, 1'b0, PAT_C);
        vecs[6] = mk(1'b0, 15'h1000, 14'h0100, 14'h0400, ST_B, 4'h3, 16'h0056, PAT_D, 8, 9, 1, 1'b0, PAT_D);

        rst_n            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_we       = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_stride_x = '0;
        bus.cmd_stride_y = '0;
        bus.cmd_dat      = '0;
        bus.cmd_tag      = '0;
        bus.dc_dat_r     = JUNK;
        bus.dc_stall     = 1'b0;
        bus.rsp_ready    = 1'b0;
        step();
        step();
        chk_reset_vals();
`ifdef DCACHE_TILE_PERF_EN
        chk("rst_perf", perf_stall_cnt, '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_reset_vals();

        // Back-to-back table commands, each starting on the single IDLE cycle.
        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end
`ifdef DCACHE_TILE_PERF_EN
        chk("perf_table_total", perf_stall_cnt, 32'd10);
`endif

        // Reset while a store is in WAIT: dc_we must drop without a clock edge.
        bus.cmd_valid    = 1'b1;
        bus.cmd_we       = 1'b1;
        bus.cmd_addr     = 15'h0ABC;
        bus.cmd_stride_x = 14'h0003;
        bus.cmd_stride_y = 14'h0030;
        bus.cmd_dat      = ST_A;
        bus.cmd_tag      = 4'hC;
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("wait_dc_we", bus.dc_we, 1'b1);
        chk("wait_dc_addr", bus.dc_addr, 15'h0ABC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dc_we", bus.dc_we, 1'b0);
        chk("async_cmd_ready", bus.cmd_ready, 1'b1);
        chk("async_dc_addr", bus.dc_addr, '0);
        chk("async_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
            chk("post_rst_dc_we", bus.dc_we, 1'b0);
        end
        bus.rsp_ready = 1'b0;

`ifdef DCACHE_TILE_PERF_EN
        // Two commands with 3 and 4 stall cycles after a fresh reset.
        chk("perf_after_rst", perf_stall_cnt, '0);
        run_vec(1);
        run_vec(6);
        chk("perf_two_cmds", perf_stall_cnt, 32'd7);
`endif

        // A fresh command still works after the mid-flight reset.
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
